// File: rtl/axi4_stream_multiple_downsizer_pkg.sv
// Shared state encoding for the AXI4-Stream wide-to-narrow downsizer.
package axi4_stream_multiple_downsizer_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } state_e;

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle; tkeep/tstrb carry one bit per tdata byte.
interface axi4_stream_if #(
    parameter int TDATA_WIDTH = 32,
    parameter int ID_WIDTH    = 4,
    parameter int DEST_WIDTH  = 4,
    parameter int USER_WIDTH  = 1
);
    localparam int KEEP_WIDTH = TDATA_WIDTH / 8;

    logic [TDATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0]  tkeep;
    logic [KEEP_WIDTH-1:0]  tstrb;
    logic                   tvalid;
    logic                   tready;
    logic                   tlast;
    logic [ID_WIDTH-1:0]    tid;
    logic [DEST_WIDTH-1:0]  tdest;
    logic [USER_WIDTH-1:0]  tuser;

    modport master (
        output tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser,
        output tready
    );

endinterface

// File: rtl/axi4_stream_keep_last_lane.sv
// Priority encoder: index of the highest narrow lane with any tkeep bit set
// (0 when tkeep is all zero).
module axi4_stream_keep_last_lane #(
    parameter int  RATIO      = 2,
    parameter int  LANE_BYTES = 4,
    localparam int LANE_W     = $clog2(RATIO)
) (
    input  logic [RATIO*LANE_BYTES-1:0] keep,
    output logic [LANE_W-1:0]           last_lane
);

    always_comb begin
        last_lane = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (|keep[i*LANE_BYTES +: LANE_BYTES]) begin
                last_lane = LANE_W'(i);
            end
        end
    end

endmodule

// File: rtl/axi4_stream_multiple_downsizer.sv
// Splits each wide AXI4-Stream beat into RATIO narrow beats, LSB lane first,
// trimming unused trailing lanes of tlast beats. All outputs are registered.
module axi4_stream_multiple_downsizer
    import axi4_stream_multiple_downsizer_pkg::*;
#(
    parameter int SLAVE_TDATA_WIDTH  = 64,
    parameter int MASTER_TDATA_WIDTH = 32,
    parameter int ID_WIDTH           = 4,
    parameter int DEST_WIDTH         = 4,
    parameter int USER_WIDTH         = 1
) (
    input logic            clk_i,
    input logic            rst_n_i,
    axi4_stream_if.slave   pkt_i,
    axi4_stream_if.master  pkt_o
);

    localparam int RATIO         = SLAVE_TDATA_WIDTH / MASTER_TDATA_WIDTH;
    localparam int LANE_W        = $clog2(RATIO);
    localparam int SLAVE_KEEP_W  = SLAVE_TDATA_WIDTH / 8;
    localparam int MASTER_KEEP_W = MASTER_TDATA_WIDTH / 8;

    state_e state, state_next;
    logic   load, advance, in_hs, out_hs, at_last, first, first_next;

    logic [LANE_W-1:0] lane, last_lane, next_lane, keep_last_lane, in_last_lane;

    logic [SLAVE_TDATA_WIDTH-1:0] buf_data;
    logic [SLAVE_KEEP_W-1:0]      buf_keep, buf_strb;
    logic                         buf_last;

    logic [MASTER_TDATA_WIDTH-1:0] out_data;
    logic [MASTER_KEEP_W-1:0]      out_keep, out_strb;
    logic                          out_last;
    logic [ID_WIDTH-1:0]           out_id;
    logic [DEST_WIDTH-1:0]         out_dest;
    logic [USER_WIDTH-1:0]         out_user;

    axi4_stream_keep_last_lane #(
        .RATIO      (RATIO),
        .LANE_BYTES (MASTER_KEEP_W)
    ) u_keep_last_lane (
        .keep      (pkt_i.tkeep),
        .last_lane (keep_last_lane)
    );

    assign out_hs       = (state == SEND) && pkt_o.tready;
    assign at_last      = (lane == last_lane);
    assign pkt_i.tready = (state == EMPTY) || (at_last && out_hs);
    assign in_hs        = pkt_i.tvalid && pkt_i.tready;
    assign next_lane    = lane + 1'b1;
    assign in_last_lane = pkt_i.tlast ? keep_last_lane : LANE_W'(RATIO - 1);

    // A beat loaded on the closing handshake of a tlast beat starts a new packet.
    assign first_next = !out_hs ? first : (at_last && buf_last);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        advance    = 1'b0;
        case (state)
            EMPTY: begin
                if (in_hs) begin
                    state_next = SEND;
                    load       = 1'b1;
                end
            end
            SEND: begin
                if (out_hs) begin
                    if (!at_last) begin
                        advance = 1'b1;
                    end else if (in_hs) begin
                        load = 1'b1;
                    end else begin
                        state_next = EMPTY;
                    end
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Lane 0 goes straight from the input to the output registers; later lanes come from the buffer.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            first     <= 1'b1;
            lane      <= '0;
            last_lane <= '0;
            buf_data  <= '0;
            buf_keep  <= '0;
            buf_strb  <= '0;
            buf_last  <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_strb  <= '0;
            out_last  <= 1'b0;
            out_id    <= '0;
            out_dest  <= '0;
            out_user  <= '0;
        end else begin
            first <= first_next;
            if (load) begin
                lane      <= '0;
                last_lane <= in_last_lane;
                buf_data  <= pkt_i.tdata;
                buf_keep  <= pkt_i.tkeep;
                buf_strb  <= pkt_i.tstrb;
                buf_last  <= pkt_i.tlast;
                out_data  <= pkt_i.tdata[MASTER_TDATA_WIDTH-1:0];
                out_keep  <= pkt_i.tkeep[MASTER_KEEP_W-1:0];
                out_strb  <= pkt_i.tstrb[MASTER_KEEP_W-1:0];
                out_last  <= pkt_i.tlast && (in_last_lane == '0);
                out_id    <= pkt_i.tid;
                out_dest  <= pkt_i.tdest;
                out_user  <= first_next ? pkt_i.tuser : '0;
            end else if (advance) begin
                lane     <= next_lane;
                out_data <= buf_data[int'(next_lane)*MASTER_TDATA_WIDTH +: MASTER_TDATA_WIDTH];
                out_keep <= buf_keep[int'(next_lane)*MASTER_KEEP_W +: MASTER_KEEP_W];
                out_strb <= buf_strb[int'(next_lane)*MASTER_KEEP_W +: MASTER_KEEP_W];
                out_last <= buf_last && (next_lane == last_lane);
                out_user <= '0;
            end
        end
    end

    assign pkt_o.tvalid = (state == SEND);
    assign pkt_o.tdata  = out_data;
    assign pkt_o.tkeep  = out_keep;
    assign pkt_o.tstrb  = out_strb;
    assign pkt_o.tlast  = out_last;
    assign pkt_o.tid    = out_id;
    assign pkt_o.tdest  = out_dest;
    assign pkt_o.tuser  = out_user;

endmodule

// File: tb/tb_axi4_stream_multiple_downsizer.sv
// Randomized scoreboard bench for axi4_stream_multiple_downsizer with directed corner cases.
module tb_axi4_stream_multiple_downsizer;

    localparam int SW    = 64;
    localparam int MW    = 32;
    localparam int IDW   = 4;
    localparam int DW    = 4;
    localparam int UW    = 1;
    localparam int RATIO = SW / MW;
    localparam int LB    = MW / 8;
    localparam int SB    = SW / 8;

    typedef struct packed {
        logic [MW-1:0]  data;
        logic [LB-1:0]  keep;
        logic [LB-1:0]  strb;
        logic           last;
        logic [IDW-1:0] id;
        logic [DW-1:0]  dest;
        logic [UW-1:0]  user;
    } narrow_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi4_stream_if #(.TDATA_WIDTH(SW), .ID_WIDTH(IDW), .DEST_WIDTH(DW), .USER_WIDTH(UW)) s_if();
    axi4_stream_if #(.TDATA_WIDTH(MW), .ID_WIDTH(IDW), .DEST_WIDTH(DW), .USER_WIDTH(UW)) m_if();

    axi4_stream_multiple_downsizer #(
        .SLAVE_TDATA_WIDTH  (SW),
        .MASTER_TDATA_WIDTH (MW),
        .ID_WIDTH           (IDW),
        .DEST_WIDTH         (DW),
        .USER_WIDTH         (UW)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .pkt_i   (s_if),
        .pkt_o   (m_if)
    );

    narrow_t exp_q[$];
    narrow_t out_log[$];
    int      check_count = 0;
    int      pass_count  = 0;
    bit      model_first = 1'b1;
    int      ready_mode  = 0;
    int      run_len     = 0;
    int      max_run     = 0;
    bit      held        = 1'b0;
    narrow_t held_beat;

    function automatic void checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endfunction

    function automatic narrow_t currentBeat();
        narrow_t b;
        b.data = m_if.tdata;  b.keep = m_if.tkeep; b.strb = m_if.tstrb;
        b.last = m_if.tlast;  b.id   = m_if.tid;   b.dest = m_if.tdest;
        b.user = m_if.tuser;
        return b;
    endfunction

    // Reference model: byte-level view of which narrow beats a wide beat produces.
    function automatic void modelBeat(logic [SW-1:0] data, logic [SB-1:0] keep, logic [SB-1:0] strb,
                                      logic last, logic [IDW-1:0] id, logic [DW-1:0] dest,
                                      logic [UW-1:0] user);
        int      top_byte = -1;
        int      n_beats;
        narrow_t e;
        for (int b = 0; b < SB; b++) if (keep[b]) top_byte = b;
        n_beats = !last ? RATIO : (top_byte < 0 ? 1 : top_byte / LB + 1);
        for (int l = 0; l < n_beats; l++) begin
            e.data = data[l*MW +: MW];
            e.keep = keep[l*LB +: LB];
            e.strb = strb[l*LB +: LB];
            e.last = last && (l == n_beats - 1);
            e.id   = id;
            e.dest = dest;
            e.user = model_first ? user : '0;
            model_first = e.last;
            exp_q.push_back(e);
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && s_if.tvalid && s_if.tready)
            modelBeat(s_if.tdata, s_if.tkeep, s_if.tstrb, s_if.tlast, s_if.tid, s_if.tdest, s_if.tuser);
    end

    always @(negedge clk) begin
        narrow_t got, e;
        if (!rst_n) begin
            held    = 1'b0;
            run_len = 0;
        end else begin
            got = currentBeat();
            if (held) checkOutput("stall_stable", got, held_beat);
            if (m_if.tvalid && m_if.tready) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
                out_log.push_back(got);
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_beat", got, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("out_data", got.data, e.data);
                    checkOutput("out_keep_strb", {got.keep, got.strb}, {e.keep, e.strb});
                    checkOutput("out_last", got.last, e.last);
                    checkOutput("out_user", got.user, e.user);
                    checkOutput("out_id_dest", {got.id, got.dest}, {e.id, e.dest});
                end
            end else begin
                run_len = 0;
            end
            held      = m_if.tvalid && !m_if.tready;
            held_beat = got;
        end
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       m_if.tready = 1'b1;
            1:       m_if.tready = 1'($urandom_range(0, 1));
            default: m_if.tready = ~m_if.tready;
        endcase
    end

    // Called at posedge+1; returns at posedge+1 right after the input handshake.
    task automatic applyStimulus(input logic [SW-1:0] data, input logic [SB-1:0] keep,
                                 input logic [SB-1:0] strb, input logic last,
                                 input logic [IDW-1:0] id, input logic [DW-1:0] dest,
                                 input logic [UW-1:0] user);
        bit done = 1'b0;
        s_if.tdata = data;  s_if.tkeep = keep; s_if.tstrb = strb; s_if.tlast = last;
        s_if.tid   = id;    s_if.tdest = dest; s_if.tuser = user; s_if.tvalid = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            done = s_if.tready;
            @(posedge clk);
            #1;
        end
        s_if.tvalid = 1'b0;
        if (!done) checkOutput("in_handshake_timeout", 0, 1);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 500; c++) begin
            if (exp_q.size() == 0 && !m_if.tvalid) break;
            @(posedge clk);
            #1;
        end
        checkOutput("drain_queue_empty", exp_q.size(), 0);
        checkOutput("drain_valid_low", m_if.tvalid, 0);
        checkOutput("idle_in_ready", s_if.tready, 1);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tstrb = '0;
        s_if.tlast  = 1'b0; s_if.tid   = '0; s_if.tdest = '0; s_if.tuser = '0;
        m_if.tready = 1'b1;
        #22;
        checkOutput("reset_valid", m_if.tvalid, 0);
        checkOutput("reset_fields", currentBeat(), 0);
        checkOutput("reset_in_ready", s_if.tready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idleCycles(1);

        $display("[TB] full-keep tlast beat");
        out_log.delete();
        applyStimulus(64'h1122334455667788, 8'hFF, 8'hFF, 1'b1, 4'h3, 4'h5, 1'b1);
        drain();
        checkOutput("full_beat_count", out_log.size(), 2);
        if (out_log.size() == 2) begin
            checkOutput("full_beat_lane0", {out_log[0].data, out_log[0].user, out_log[0].last}, {32'h55667788, 1'b1, 1'b0});
            checkOutput("full_beat_lane1", {out_log[1].data, out_log[1].user, out_log[1].last}, {32'h11223344, 1'b0, 1'b1});
        end

        $display("[TB] half-keep tlast beat");
        out_log.delete();
        applyStimulus(64'h1122334455667788, 8'h0F, 8'h0F, 1'b1, 4'h1, 4'h2, 1'b1);
        drain();
        checkOutput("half_keep_count", out_log.size(), 1);
        if (out_log.size() == 1)
            checkOutput("half_keep_beat", {out_log[0].data, out_log[0].keep, out_log[0].last}, {32'h55667788, 4'hF, 1'b1});

        $display("[TB] back-to-back beats");
        max_run = 0;
        for (int i = 0; i < 4; i++)
            applyStimulus({$urandom, $urandom}, 8'hFF, 8'($urandom), i == 3, 4'(i), 4'(i + 8), 1'b1);
        drain();
        checkOutput("no_bubble_run", max_run, 8);

        $display("[TB] alternating output ready");
        out_log.delete();
        m_if.tready = 1'b1;
        ready_mode  = 2;
        applyStimulus(64'hAAAA0001BBBB0002, 8'hFF, 8'hF0, 1'b0, 4'h7, 4'h6, 1'b1);
        applyStimulus(64'hCCCC0003DDDD0004, 8'hFF, 8'h0F, 1'b1, 4'h7, 4'h6, 1'b0);
        drain();
        ready_mode = 0;
        checkOutput("alt_ready_count", out_log.size(), 4);

        $display("[TB] reset mid-beat");
        applyStimulus(64'h0123456789ABCDEF, 8'hFF, 8'hFF, 1'b0, 4'h2, 4'h3, 1'b0);
        idleCycles(1);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_valid", m_if.tvalid, 0);
        checkOutput("midreset_data", m_if.tdata, 0);
        exp_q.delete();
        model_first = 1'b1;
        idleCycles(2);
        rst_n = 1'b1;
        idleCycles(1);
        out_log.delete();
        applyStimulus(64'hFEDCBA9876543210, 8'hFF, 8'hFF, 1'b1, 4'h4, 4'h9, 1'b1);
        drain();
        if (out_log.size() > 0)
            checkOutput("postreset_first", {out_log[0].data, out_log[0].user}, {32'h76543210, 1'b1});
        else
            checkOutput("postreset_first_missing", 0, 1);

        $display("[TB] zero-keep tlast beat");
        out_log.delete();
        applyStimulus(64'h5555666677778888, 8'h00, 8'h00, 1'b1, 4'hA, 4'hB, 1'b1);
        drain();
        checkOutput("zero_keep_count", out_log.size(), 1);
        if (out_log.size() == 1)
            checkOutput("zero_keep_beat", {out_log[0].keep, out_log[0].last}, {4'h0, 1'b1});

        $display("[TB] randomized traffic");
        for (int i = 0; i < 80; i++) begin
            if (i % 20 == 0) ready_mode = int'($urandom_range(0, 1));
            applyStimulus({$urandom, $urandom},
                          ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                          8'($urandom), 1'($urandom_range(0, 2) == 0),
                          4'($urandom), 4'($urandom), 1'($urandom));
            idleCycles(int'($urandom_range(0, 2)));
        end
        ready_mode = 0;
        drain();

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
